// File: rtl/pak_dsp_wb_master_if.sv
// Wishbone classic link between the configuration master and a register responder.
interface pak_dsp_wb_master_if;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_dat_i, wbm_ack_i
  );

  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_dat_i, wbm_ack_i
  );
endinterface

// File: rtl/pak_dsp_wb_master.sv
// Table-driven Wishbone configuration master: writes up to DEPTH (addr, data)
// entries to a responder, optionally reads them back and flags the first mismatch.
module pak_dsp_wb_master #(
  parameter int DEPTH   = 8,
  parameter int DATA_W  = 14,
  parameter int ADDR_W  = 6,
  parameter int TIMEOUT = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              load_en,
  input  logic [2:0]        load_idx,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              start,
  input  logic [3:0]        count,
  input  logic              verify,
  pak_dsp_wb_master_if.master wb,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [2:0]        err_idx
);
  typedef enum logic [2:0] {IDLE, WR, WR_GAP, RD, RD_GAP, FIN} state_t;
  localparam int TO_W = $clog2(TIMEOUT + 1);

  state_t            state;
  logic [2:0]        idx;
  logic [2:0]        last;      // index of the final entry of this sequence
  logic              vfy;       // verify request captured at start
  logic [TO_W-1:0]   tcnt;
  logic              cyc, stb, we;
  logic [3:0]        sel;
  logic [3:0]        cnt_eff;
  logic [ADDR_W-1:0] tbl_addr [DEPTH];
  logic [DATA_W-1:0] tbl_data [DEPTH];
  logic              unused_dat;

  assign cnt_eff = (int'(count) > DEPTH) ? 4'(DEPTH) : count;
  assign busy    = (state != IDLE);
  assign unused_dat = ^wb.wbm_dat_i[31:DATA_W];

  // Address/data come straight from the table so a load on the start edge is seen by the first WR.
  assign wb.wbm_cyc_o = cyc;
  assign wb.wbm_stb_o = stb;
  assign wb.wbm_we_o  = we;
  assign wb.wbm_sel_o = sel;
  assign wb.wbm_adr_o = cyc ? 32'(tbl_addr[idx]) : '0;
  assign wb.wbm_dat_o = (cyc && we) ? 32'(tbl_data[idx]) : '0;

  // Configuration table: writable only while idle so a running sequence sees a stable table.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_addr[i] <= '0;
        tbl_data[i] <= '0;
      end
    end else if (load_en && state == IDLE && int'(load_idx) < DEPTH) begin
      tbl_addr[load_idx] <= load_addr;
      tbl_data[load_idx] <= load_data;
    end
  end

  // Sequencer: write phase, optional read-back phase, ack timeout, end-of-sequence pulse.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state   <= IDLE;
      idx     <= '0;
      last    <= '0;
      vfy     <= 1'b0;
      tcnt    <= '0;
      cyc     <= 1'b0;
      stb     <= 1'b0;
      we      <= 1'b0;
      sel     <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      err_idx <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (cnt_eff == 4'd0) begin
            state <= FIN;
          end else begin
            err     <= 1'b0;
            err_idx <= '0;
            idx     <= '0;
            last    <= 3'(cnt_eff - 4'd1);
            vfy     <= verify;
            tcnt    <= '0;
            {cyc, stb, we} <= 3'b111;
            sel     <= 4'hF;
            state   <= WR;
          end
        end
        WR, RD: begin
          if (wb.wbm_ack_i) begin
            {cyc, stb, we} <= 3'b000;
            sel <= '0;
            if (state == RD && wb.wbm_dat_i[DATA_W-1:0] != tbl_data[idx]) begin
              err <= 1'b1;
              if (!err) err_idx <= idx;
            end
            state <= (state == WR) ? WR_GAP : RD_GAP;
          end else if (tcnt == TO_W'(TIMEOUT - 1)) begin
            // Responder is unresponsive: abandon the whole sequence.
            {cyc, stb, we} <= 3'b000;
            sel <= '0;
            err <= 1'b1;
            if (!err) err_idx <= idx;
            state <= FIN;
          end else begin
            tcnt <= tcnt + TO_W'(1);
          end
        end
        WR_GAP: begin
          if (idx == last) begin
            if (vfy) begin
              idx   <= '0;
              tcnt  <= '0;
              {cyc, stb, we} <= 3'b110;
              sel   <= 4'hF;
              state <= RD;
            end else begin
              state <= FIN;
            end
          end else begin
            idx   <= idx + 3'd1;
            tcnt  <= '0;
            {cyc, stb, we} <= 3'b111;
            sel   <= 4'hF;
            state <= WR;
          end
        end
        RD_GAP: begin
          if (idx == last) begin
            state <= FIN;
          end else begin
            idx   <= idx + 3'd1;
            tcnt  <= '0;
            {cyc, stb, we} <= 3'b110;
            sel   <= 4'hF;
            state <= RD;
          end
        end
        FIN: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pak_dsp_wb_master.sv
// Bench for pak_dsp_wb_master: transaction-level model (expected bus transfer list,
// latency formula, first-error rule) checked against the DUT every falling edge.
module tb_pak_dsp_wb_master;
  localparam int TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_en = 1'b0;
  logic [2:0]  load_idx = '0;
  logic [5:0]  load_addr = '0;
  logic [13:0] load_data = '0;
  logic        start = 1'b0;
  logic [3:0]  count = '0;
  logic        verify = 1'b0;
  logic        busy, done, err;
  logic [2:0]  err_idx;

  pak_dsp_wb_master_if bus();

  pak_dsp_wb_master #(.DEPTH(8), .DATA_W(14), .ADDR_W(6), .TIMEOUT(TIMEOUT)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .load_en(load_en), .load_idx(load_idx),
    .load_addr(load_addr), .load_data(load_data), .start(start), .count(count),
    .verify(verify), .wb(bus), .busy(busy), .done(done), .err(err), .err_idx(err_idx)
  );

  always #5 clk = ~clk;

  // ---------------- responder ----------------
  int          ack_total = 0, wcnt = 0, wtarget = 0, hang_at = -1, maxw = 0, bad_adr = -1;
  logic [13:0] bad_val = '0;
  logic [13:0] rmem [64];
  logic        ack_ok;

  always_comb ack_ok = bus.wbm_stb_o && (ack_total != hang_at) && (wcnt >= wtarget);
  assign bus.wbm_ack_i = ack_ok;
  assign bus.wbm_dat_i = (int'(bus.wbm_adr_o[5:0]) == bad_adr) ? {18'd0, bad_val}
                                                               : {18'd0, rmem[bus.wbm_adr_o[5:0]]};

  always @(posedge clk) begin
    if (ack_ok) begin
      ack_total <= ack_total + 1;
      if (bus.wbm_we_o) rmem[bus.wbm_adr_o[5:0]] <= bus.wbm_dat_o[13:0];
    end
    if (bus.wbm_stb_o && !ack_ok) wcnt <= wcnt + 1;
    else begin
      wcnt    <= 0;
      wtarget <= (maxw == 0) ? 0 : int'($urandom_range(32'(maxw), 32'd0));
    end
  end

  // ---------------- model ----------------
  typedef struct { bit we; logic [5:0] adr; logic [13:0] dat; } xact_t;
  xact_t       exp_q[$];
  logic [5:0]  m_adr [8];
  logic [13:0] m_dat [8];
  bit          m_err = 0;
  int          m_eidx = 0;
  bit          exp_hang = 0;
  int          exp_acks = 0, exp_lat = -1, lit_lat = -1, lit_err = -1, lit_eidx = -1;
  int          s_start = 0, run_id = 0;

  task automatic flag_err(input int i);
    if (!m_err) m_eidx = i;
    m_err = 1;
  endtask

  // ---------------- checker ----------------
  int neg_cnt = 0, total = 0, bad = 0, ptr = 0, seen_run = 0, cur_run = 0, max_run = 0, done_cnt = 0;
  bit active = 0;

  task automatic ck(inout int t, inout int b, input string nm, input longint act, input longint exp);
    t++;
    if (act != exp) begin
      b++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : cmp
    int t, b, now, p, cr, mr;
    bit act, fresh;
    t = 0; b = 0; now = neg_cnt + 1;
    fresh = (run_id != seen_run);
    p  = fresh ? 0 : ptr;
    cr = fresh ? 0 : cur_run;
    mr = fresh ? 0 : max_run;
    act = fresh || active;
    if (rst) begin
      ck(t, b, "rst_cyc", bus.wbm_cyc_o, 0);
      ck(t, b, "rst_stb", bus.wbm_stb_o, 0);
      ck(t, b, "rst_we", bus.wbm_we_o, 0);
      ck(t, b, "rst_sel", bus.wbm_sel_o, 0);
      ck(t, b, "rst_adr", bus.wbm_adr_o, 0);
      ck(t, b, "rst_dat", bus.wbm_dat_o, 0);
      ck(t, b, "rst_busy", busy, 0);
      ck(t, b, "rst_done", done, 0);
      ck(t, b, "rst_err", err, 0);
      ck(t, b, "rst_err_idx", err_idx, 0);
      act = 0;
    end else begin
      ck(t, b, "cyc_vs_stb", bus.wbm_cyc_o, bus.wbm_stb_o);
      ck(t, b, "busy", busy, act && !done);
      if (bus.wbm_stb_o) begin
        cr++;
        if (p < exp_q.size()) begin
          ck(t, b, "adr", bus.wbm_adr_o, longint'(exp_q[p].adr));
          ck(t, b, "we", bus.wbm_we_o, exp_q[p].we);
          ck(t, b, "sel", bus.wbm_sel_o, 4'hF);
          if (exp_q[p].we) ck(t, b, "dat", bus.wbm_dat_o, longint'(exp_q[p].dat));
        end else begin
          ck(t, b, "unexpected_stb", bus.wbm_stb_o, 0);
        end
        if (bus.wbm_ack_i) p++;
      end else begin
        cr = 0;
      end
      if (cr > mr) mr = cr;
      if (done) begin
        if (!act) ck(t, b, "stray_done", done, 0);
        else begin
          if (exp_lat >= 0) ck(t, b, "latency", now - s_start, exp_lat);
          if (lit_lat >= 0) ck(t, b, "latency_lit", now - s_start, lit_lat);
          ck(t, b, "err", err, m_err);
          ck(t, b, "err_idx", err_idx, m_eidx);
          if (lit_err >= 0) begin
            ck(t, b, "err_lit", err, lit_err);
            ck(t, b, "err_idx_lit", err_idx, lit_eidx);
          end
          ck(t, b, "acked_xfers", p, exp_acks);
          if (exp_hang) ck(t, b, "stb_hold_cycles", mr, TIMEOUT);
          act = 0;
          done_cnt <= done_cnt + 1;
        end
      end else if (act && (now - s_start) > 4000) begin
        ck(t, b, "done_watchdog", done, 1);
        act = 0;
        done_cnt <= done_cnt + 1;
      end
    end
    neg_cnt  <= now;
    total    <= total + t;
    bad      <= bad + b;
    ptr      <= p;
    cur_run  <= cr;
    max_run  <= mr;
    active   <= act;
    seen_run <= run_id;
  end

  // ---------------- stimulus ----------------
  task automatic do_reset(input int n);
    rst = 1; start = 0; load_en = 0;
    for (int i = 0; i < 8; i++) begin m_adr[i] = '0; m_dat[i] = '0; end
    m_err = 0; m_eidx = 0;
    repeat (n) begin @(negedge clk); #1; end
    rst = 0;
  endtask

  task automatic load(input int i, input logic [5:0] a, input logic [13:0] d);
    load_en = 1; load_idx = 3'(i); load_addr = a; load_data = d;
    m_adr[i] = a; m_dat[i] = d;
    @(negedge clk); #1;
    load_en = 0;
  endtask

  task automatic arm(input int cnt, input bit vfy, input int hang_k, input int mw,
                     input int badadr, input logic [13:0] badval,
                     input int llat, input int lerr, input int leidx,
                     input bit ld, input int li, input logic [5:0] la, input logic [13:0] lv);
    int n; bit hung; xact_t x;
    if (ld) begin
      load_en = 1; load_idx = 3'(li); load_addr = la; load_data = lv;
      m_adr[li] = la; m_dat[li] = lv;
    end
    maxw = mw; bad_adr = badadr; bad_val = badval;
    hang_at = (hang_k < 0) ? -1 : ack_total + hang_k;
    n = (cnt > 8) ? 8 : cnt;
    exp_q.delete(); hung = 0;
    if (n > 0) begin m_err = 0; m_eidx = 0; end
    for (int i = 0; i < n && !hung; i++) begin
      x.we = 1; x.adr = m_adr[i]; x.dat = m_dat[i];
      exp_q.push_back(x);
      if (i == hang_k) begin hung = 1; flag_err(i); end
    end
    if (!hung && vfy) for (int i = 0; i < n; i++) begin
      x.we = 0; x.adr = m_adr[i]; x.dat = m_dat[i];
      exp_q.push_back(x);
      if (((int'(m_adr[i]) == badadr) ? badval : m_dat[i]) != m_dat[i]) flag_err(i);
    end
    exp_hang = hung;
    exp_acks = hung ? exp_q.size() - 1 : exp_q.size();
    exp_lat  = (mw == 0 && !hung) ? n * 2 * (vfy ? 2 : 1) + 2 : -1;
    lit_lat = llat; lit_err = lerr; lit_eidx = leidx;
    s_start = neg_cnt;
    count = 4'(cnt); verify = vfy; start = 1; run_id++;
    @(negedge clk); #1;
    start = 0; load_en = 0;
  endtask

  task automatic wait_done(input bit poke);
    int d0, k;
    d0 = done_cnt; k = 0;
    while (done_cnt == d0) begin
      @(negedge clk); #1; k++;
      if (poke && k == 3) begin
        start = 1; count = 4'd1; load_en = 1; load_idx = 3'd0;
        load_addr = 6'h2A; load_data = 14'h1555;
      end else begin
        start = 0; load_en = 0;
      end
    end
  endtask

  initial begin
    do_reset(3);
    // Table cleared by reset; start in the same cycle reset falls.
    arm(2, 0, -1, 0, -1, 14'h0, 6, 0, 0, 0, 0, 6'h0, 14'h0);       wait_done(0);
    load(0, 6'h01, 14'h0123); load(1, 6'h02, 14'h3FFF); load(2, 6'h05, 14'h0000);
    arm(3, 0, -1, 0, -1, 14'h0, 8, 0, 0, 0, 0, 6'h0, 14'h0);       wait_done(0);
    arm(3, 1, -1, 0, 2, 14'h3FFE, 14, 1, 1, 0, 0, 6'h0, 14'h0);    wait_done(0);
    // count=0 leaves the sticky error from the previous run untouched.
    arm(0, 0, -1, 0, -1, 14'h0, 2, 1, 1, 0, 0, 6'h0, 14'h0);       wait_done(0);
    // Load together with start: new entry 3 must be used.
    arm(4, 1, -1, 0, -1, 14'h0, 18, 0, 0, 1, 3, 6'h3F, 14'h2AAA);  wait_done(0);
    for (int i = 4; i < 8; i++) load(i, 6'(6'h10 + i), 14'(14'h1000 + i * 14'h111));
    // count above DEPTH clamps to 8 entries.
    arm(12, 1, -1, 0, -1, 14'h0, 34, 0, 0, 0, 0, 6'h0, 14'h0);     wait_done(0);
    // Second write never acked: timeout.
    arm(3, 0, 1, 0, -1, 14'h0, -1, 1, 1, 0, 0, 6'h0, 14'h0);       wait_done(0);
    // Random wait states, start/load poked while busy.
    arm(4, 1, -1, 3, -1, 14'h0, -1, 0, 0, 0, 0, 6'h0, 14'h0);      wait_done(1);
    // Entry 0 must still be the original (0x01, 0x0123).
    arm(1, 1, -1, 0, -1, 14'h0, 6, 0, 0, 0, 0, 6'h0, 14'h0);       wait_done(0);
    // Reset asserted during a write wait state, between clock edges.
    arm(2, 0, 0, 0, -1, 14'h0, -1, -1, -1, 0, 0, 6'h0, 14'h0);
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    do_reset(2);
    load(0, 6'h07, 14'h0ABC);
    arm(1, 1, -1, 0, -1, 14'h0, 6, 0, 0, 0, 0, 6'h0, 14'h0);       wait_done(0);
    repeat (3) @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pak_dsp_wb_master.md
PAK_DSP_WB_MASTER -- requirements
Module: pak_dsp_wb_master

Interface
REQ-001 SHALL have parameter DEPTH, default 8: number of (address, data) entries in the configuration table.
REQ-002 SHALL have parameter DATA_W, default 14: width of each configuration data word.
REQ-003 SHALL have parameter ADDR_W, default 6: width of each target register address.
REQ-004 SHALL have parameter TIMEOUT, default 255: number of cycles to wait for an ack before aborting.
REQ-005 SHALL have one clock and an asynchronous, active-high reset.
REQ-006 wb_clk_i  in  1  clock; all logic on its rising edge.
REQ-007 wb_rst_i  in  1  asynchronous active-high reset.
REQ-008 load_en  in  1  write a table entry this cycle.
REQ-009 load_idx  in  3  table index to write.
REQ-010 load_addr  in  ADDR_W  target register address.
REQ-011 load_data  in  DATA_W  target register data.
REQ-012 start  in  1  begin a sequence; sampled as a level.
REQ-013 count  in  4  number of entries to transfer; values above DEPTH clamp to DEPTH.
REQ-014 verify  in  1  read back and compare after the write phase.
REQ-015 wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  Wishbone classic initiator controls.
REQ-016 wbm_sel_o  out  4  byte select.
REQ-017 wbm_adr_o  out  32  address, {zeros, addr}.
REQ-018 wbm_dat_o  out  32  write data, {zeros, data}.
REQ-019 wbm_dat_i  in  32  read data.
REQ-020 wbm_ack_i  in  1  responder acknowledge.
REQ-021 busy  out  1  high whenever the FSM is not in IDLE.
REQ-022 done  out  1  one-cycle end-of-sequence pulse.
REQ-023 err  out  1  sticky error flag.
REQ-024 err_idx  out  3  index of the first failing entry.

Function
REQ-025 FSM states: IDLE, WR, WR_GAP, RD, RD_GAP, FIN.
REQ-026 IDLE, start=1, count=0: go to FIN; no bus cycle issued.
REQ-027 IDLE, start=1, count>0: clear err and err_idx, set idx=0, go to WR.
REQ-028 WR: cyc=stb=we=1, sel=4'hF, adr/dat from table[idx]; outputs held stable until ack.
REQ-029 WR with ack=1: go to WR_GAP; cyc=stb=0 for exactly one cycle.
REQ-030 WR_GAP leaving the last entry (idx=count-1): go to RD with idx=0 if verify=1, else FIN.
REQ-031 WR_GAP otherwise: idx+1, back to WR.
REQ-032 RD: cyc=stb=1, we=0, adr from table[idx]; wbm_dat_o is don't-care.
REQ-033 RD with ack=1: compare wbm_dat_i[DATA_W-1:0] with table[idx].data, then go to RD_GAP.
REQ-034 RD mismatch: set err; latch err_idx only if err was previously 0.
REQ-035 RD mismatch does not stop the sequence: remaining entries are still read.
REQ-036 RD_GAP: next RD, or FIN after the last entry.
REQ-037 FIN: done=1 for one cycle, then IDLE.
REQ-038 Latency: start sampled at edge N; first stb high during cycle N+1.
REQ-039 With zero-wait acks, each transfer takes 2 cycles.
REQ-040 Total sequence time: count*2*(1+verify) + 2 cycles from start to done.
REQ-041 Timeout counter resets on entry to WR/RD and counts each cycle without ack.
REQ-042 Timeout reaching TIMEOUT: drop cyc/stb the next cycle, set err, latch err_idx=idx (first-error rule), go to FIN.
REQ-043 start while busy: ignored.
REQ-044 load_en while busy: ignored, so the table stays stable during a sequence.
REQ-045 load_en in IDLE: writes the table on the same edge.
REQ-046 load_en together with start in IDLE: the table write takes effect before the first WR reads it.
REQ-047 Acks arriving while stb=0 are ignored.

Reset
REQ-048 wb_rst_i=1 forces state IDLE, idx=0 and timeout counter=0 immediately, regardless of the clock.
REQ-049 During reset all outputs are 0: cyc, stb, we, sel, adr, dat, busy, done, err, err_idx.
REQ-050 Table contents are also cleared to 0 by reset.
REQ-051 Reset mid-transfer drops cyc/stb asynchronously; no done is generated.
REQ-052 First start is accepted on the first edge after wb_rst_i falls.

Verification
REQ-053 Load 3 entries {(0x01,0x0123),(0x02,0x3FFF),(0x05,0x0000)}, count=3, verify=0, zero-wait ack -> 3 write cycles with those adr/dat; done 8 cycles after start; err=0.
REQ-054 Same table, verify=1, responder returns 0x3FFE for addr 0x02 -> 3 writes then 3 reads; err=1, err_idx=1, done after 14 cycles.
REQ-055 count=0 -> no cyc assertion; done pulses 2 cycles after start.
REQ-056 Responder never acks the 2nd write -> stb held for 255 cycles, then dropped; err=1, err_idx=1, done pulses; no further bus cycles.
REQ-057 Assert wb_rst_i during a WR wait state -> cyc/stb/busy go to 0 with no clock edge; subsequent count=1 run completes normally.
REQ-058 start and load_en pulsed while busy -> no effect on the sequence or the table; responder with random 0-3 wait states -> adr/dat stable while stb is high.
